// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes the MIPS instruction leaving ID, forwards operands,
// and registers the {ope_sel, data_a, data_b} triple consumed by the ALU in EX.
module alu_issue_stage #(
  parameter int NB_DATA = 32,
  parameter int NB_OPE  = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  input  logic               i_stall,
  input  logic               i_flush,
  input  logic [5:0]         i_opcode,
  input  logic [5:0]         i_funct,
  input  logic [4:0]         i_shamt,
  input  logic [15:0]        i_imm,
  input  logic [NB_DATA-1:0] i_pc,
  input  logic [NB_DATA-1:0] i_rs_data,
  input  logic [NB_DATA-1:0] i_rt_data,
  input  logic [1:0]         i_fwd_a_sel,
  input  logic [1:0]         i_fwd_b_sel,
  input  logic [NB_DATA-1:0] i_exmem_data,
  input  logic [NB_DATA-1:0] i_memwb_data,
  output logic [NB_OPE-1:0]  o_ope_sel,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic               o_valid,
  output logic               o_illegal
);

  typedef enum logic [NB_OPE-1:0] {
    OP_AND = NB_OPE'(0),  OP_OR  = NB_OPE'(1),  OP_ADD = NB_OPE'(2),
    OP_XOR = NB_OPE'(3),  OP_SUB = NB_OPE'(6),  OP_SLT = NB_OPE'(7),
    OP_SLL = NB_OPE'(8),  OP_SRL = NB_OPE'(9),  OP_SRA = NB_OPE'(10),
    OP_NOR = NB_OPE'(12), OP_JAL = NB_OPE'(13), OP_LUI = NB_OPE'(14),
    OP_ILL = NB_OPE'(15)
  } ope_e;

  logic [NB_DATA-1:0] fwd_a, fwd_b, sext, zext, link_addr;
  ope_e               dec_ope;
  logic [NB_DATA-1:0] dec_a, dec_b;
  logic               dec_illegal;

  // Encodings 0 and 3 both select the register file read.
  always_comb begin
    case (i_fwd_a_sel)
      2'd1:    fwd_a = i_exmem_data;
      2'd2:    fwd_a = i_memwb_data;
      default: fwd_a = i_rs_data;
    endcase
    case (i_fwd_b_sel)
      2'd1:    fwd_b = i_exmem_data;
      2'd2:    fwd_b = i_memwb_data;
      default: fwd_b = i_rt_data;
    endcase
  end

  assign sext      = {{(NB_DATA-16){i_imm[15]}}, i_imm};
  assign zext      = {{(NB_DATA-16){1'b0}}, i_imm};
  assign link_addr = i_pc + NB_DATA'(8);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    dec_ope     = OP_AND;
    dec_a       = '0;
    dec_b       = '0;
    dec_illegal = 1'b0;
    if (i_opcode == 6'h00) begin
      case (i_funct)
        6'h00, 6'h02, 6'h03: begin
          dec_ope = (i_funct == 6'h00) ? OP_SLL : (i_funct == 6'h02) ? OP_SRL : OP_SRA;
          dec_a   = {{(NB_DATA-5){1'b0}}, i_shamt};
          dec_b   = fwd_b;
        end
        6'h04, 6'h06, 6'h07: begin
          dec_ope = (i_funct == 6'h04) ? OP_SLL : (i_funct == 6'h06) ? OP_SRL : OP_SRA;
          dec_a   = {{(NB_DATA-5){1'b0}}, fwd_a[4:0]};
          dec_b   = fwd_b;
        end
        6'h21: begin dec_ope = OP_ADD; dec_a = fwd_a; dec_b = fwd_b; end
        6'h23: begin dec_ope = OP_SUB; dec_a = fwd_a; dec_b = fwd_b; end
        6'h24: begin dec_ope = OP_AND; dec_a = fwd_a; dec_b = fwd_b; end
        6'h25: begin dec_ope = OP_OR;  dec_a = fwd_a; dec_b = fwd_b; end
        6'h26: begin dec_ope = OP_XOR; dec_a = fwd_a; dec_b = fwd_b; end
        6'h27: begin dec_ope = OP_NOR; dec_a = fwd_a; dec_b = fwd_b; end
        6'h2A: begin dec_ope = OP_SLT; dec_a = fwd_a; dec_b = fwd_b; end
        6'h09: begin dec_ope = OP_JAL; dec_a = link_addr; end
        default: begin dec_ope = OP_ILL; dec_illegal = 1'b1; end
      endcase
    end else begin
      case (i_opcode)
        6'h08, 6'h09: begin dec_ope = OP_ADD; dec_a = fwd_a; dec_b = sext; end
        6'h0A:        begin dec_ope = OP_SLT; dec_a = fwd_a; dec_b = sext; end
        6'h0C:        begin dec_ope = OP_AND; dec_a = fwd_a; dec_b = zext; end
        6'h0D:        begin dec_ope = OP_OR;  dec_a = fwd_a; dec_b = zext; end
        6'h0E:        begin dec_ope = OP_XOR; dec_a = fwd_a; dec_b = zext; end
        6'h0F:        begin dec_ope = OP_LUI; dec_a = NB_DATA'(16); dec_b = zext; end
        6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B: begin
          dec_ope = OP_ADD; dec_a = fwd_a; dec_b = sext;
        end
        6'h04, 6'h05: begin dec_ope = OP_SUB; dec_a = fwd_a; dec_b = fwd_b; end
        6'h03:        begin dec_ope = OP_JAL; dec_a = link_addr; end
        6'h02:        dec_ope = OP_AND;
        default:      begin dec_ope = OP_ILL; dec_illegal = 1'b1; end
      endcase
    end
  end

  // Priority: reset > flush > stall > load; an invalid load is a bubble.
  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    if (i_rst || i_flush || (!i_stall && !i_valid)) begin
      o_ope_sel <= OP_AND;
      o_data_a  <= '0;
      o_data_b  <= '0;
      o_valid   <= 1'b0;
      o_illegal <= 1'b0;
    end else if (!i_stall) begin
      o_ope_sel <= dec_ope;
      o_data_a  <= dec_a;
      o_data_b  <= dec_b;
      o_valid   <= 1'b1;
      o_illegal <= dec_illegal;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: a table of decode/forward vectors plus
// hand-written reset, stall and flush sequences.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst, valid, stall, flush;
  logic [5:0]  opcode, funct;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic [31:0] pc, rs_data, rt_data, exmem_data, memwb_data;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [3:0]  ope_sel;
  logic [31:0] data_a, data_b;
  logic        out_valid, out_illegal;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.NB_DATA(32), .NB_OPE(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_stall(stall), .i_flush(flush),
    .i_opcode(opcode), .i_funct(funct), .i_shamt(shamt), .i_imm(imm), .i_pc(pc),
    .i_rs_data(rs_data), .i_rt_data(rt_data),
    .i_fwd_a_sel(fwd_a_sel), .i_fwd_b_sel(fwd_b_sel),
    .i_exmem_data(exmem_data), .i_memwb_data(memwb_data),
    .o_ope_sel(ope_sel), .o_data_a(data_a), .o_data_b(data_b),
    .o_valid(out_valid), .o_illegal(out_illegal)
  );

  typedef struct packed {
    logic        valid;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [31:0] pc;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [31:0] exm;
    logic [31:0] mwb;
    logic [3:0]  e_ope;
    logic [31:0] e_a;
    logic [31:0] e_b;
    logic        e_valid;
    logic        e_illegal;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    valid = v.valid; opcode = v.opcode; funct = v.funct; shamt = v.shamt; imm = v.imm;
    pc = v.pc; rs_data = v.rs; rt_data = v.rt; fwd_a_sel = v.fa; fwd_b_sel = v.fb;
    exmem_data = v.exm; memwb_data = v.mwb;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] e_ope, input logic [31:0] e_a,
                            input logic [31:0] e_b, input logic e_valid, input logic e_ill);
    check({tag, ".ope"}, 32'(ope_sel), 32'(e_ope));
    check({tag, ".a"}, data_a, e_a);
    check({tag, ".b"}, data_b, e_b);
    check({tag, ".valid"}, 32'(out_valid), 32'(e_valid));
    check({tag, ".illegal"}, 32'(out_illegal), 32'(e_ill));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t addu, xorv;

  initial begin
    //          vl op     fn     sh  imm       pc            rs            rt            fa fb exm    mwb    ope a             b             v  il
    vecs[0]  = '{1, 6'h08, 6'h00, 0, 16'hFFFF, 32'h0,        32'd255,      32'h0,        0, 0, 32'h0, 32'h0, 2,  32'd255,      32'hFFFFFFFF, 1, 0}; // ADDI
    vecs[1]  = '{1, 6'h0C, 6'h00, 0, 16'hFFFF, 32'h0,        32'd255,      32'h0,        0, 0, 32'h0, 32'h0, 0,  32'd255,      32'h0000FFFF, 1, 0}; // ANDI
    vecs[2]  = '{1, 6'h00, 6'h03, 4, 16'h0,    32'h0,        32'h0,        32'hE0000080, 0, 0, 32'h0, 32'h0, 10, 32'd4,        32'hE0000080, 1, 0}; // SRA
    vecs[3]  = '{1, 6'h00, 6'h04, 0, 16'h0,    32'h0,        32'h24,       32'h1,        0, 0, 32'h0, 32'h0, 8,  32'd4,        32'h1,        1, 0}; // SLLV
    vecs[4]  = '{1, 6'h0F, 6'h00, 0, 16'h9FFF, 32'h0,        32'h0,        32'h0,        0, 0, 32'h0, 32'h0, 14, 32'd16,       32'h00009FFF, 1, 0}; // LUI
    vecs[5]  = '{1, 6'h00, 6'h23, 0, 16'h0,    32'h0,        32'h1,        32'h2,        1, 2, 32'h10, 32'h20, 6, 32'h10,       32'h20,       1, 0}; // SUBU fwd
    vecs[6]  = '{1, 6'h00, 6'h23, 0, 16'h0,    32'h0,        32'h1,        32'h2,        3, 3, 32'h10, 32'h20, 6, 32'h1,        32'h2,        1, 0}; // SUBU sel3
    vecs[7]  = '{1, 6'h03, 6'h00, 0, 16'h0,    32'hFFFFFFFC, 32'h0,        32'h0,        0, 0, 32'h0, 32'h0, 13, 32'h4,        32'h0,        1, 0}; // JAL wrap
    vecs[8]  = '{1, 6'h3F, 6'h00, 0, 16'h1234, 32'h0,        32'h55,       32'h66,       0, 0, 32'h0, 32'h0, 15, 32'h0,        32'h0,        1, 1}; // bad opcode
    vecs[9]  = '{1, 6'h00, 6'h3F, 0, 16'h0,    32'h0,        32'h55,       32'h66,       0, 0, 32'h0, 32'h0, 15, 32'h0,        32'h0,        1, 1}; // bad funct
    vecs[10] = '{1, 6'h23, 6'h00, 0, 16'h8000, 32'h0,        32'd100,      32'h0,        0, 0, 32'h0, 32'h0, 2,  32'd100,      32'hFFFF8000, 1, 0}; // LW
    vecs[11] = '{1, 6'h04, 6'h00, 0, 16'h0,    32'h0,        32'd5,        32'd7,        0, 0, 32'h0, 32'h0, 6,  32'd5,        32'd7,        1, 0}; // BEQ
    vecs[12] = '{1, 6'h02, 6'h00, 0, 16'h0,    32'h0,        32'hAA,       32'hBB,       0, 0, 32'h0, 32'h0, 0,  32'h0,        32'h0,        1, 0}; // J
    vecs[13] = '{1, 6'h00, 6'h09, 0, 16'h0,    32'h100,      32'h0,        32'h0,        0, 0, 32'h0, 32'h0, 13, 32'h108,      32'h0,        1, 0}; // JALR
    vecs[14] = '{1, 6'h00, 6'h2A, 0, 16'h0,    32'h0,        32'd3,        32'd4,        0, 0, 32'h0, 32'h0, 7,  32'd3,        32'd4,        1, 0}; // SLT
    vecs[15] = '{1, 6'h0D, 6'h00, 0, 16'h1234, 32'h0,        32'hF0000000, 32'h0,        0, 0, 32'h0, 32'h0, 1,  32'hF0000000, 32'h00001234, 1, 0}; // ORI
    vecs[16] = '{1, 6'h00, 6'h06, 0, 16'h0,    32'h0,        32'h3F,       32'h80000000, 0, 0, 32'h0, 32'h0, 9,  32'h1F,       32'h80000000, 1, 0}; // SRLV
    vecs[17] = '{1, 6'h00, 6'h27, 7, 16'h0,    32'h0,        32'h0F,       32'hF0,       0, 0, 32'h0, 32'h0, 12, 32'h0F,       32'hF0,       1, 0}; // NOR
    vecs[18] = '{0, 6'h00, 6'h21, 0, 16'h0,    32'h0,        32'd9,        32'd9,        0, 0, 32'h0, 32'h0, 0,  32'h0,        32'h0,        0, 0}; // bubble

    addu = '{1, 6'h00, 6'h21, 0, 16'h0, 32'h0, 32'd3, 32'd4, 0, 0, 32'h0, 32'h0, 2, 32'd3, 32'd4, 1, 0};
    xorv = '{1, 6'h00, 6'h26, 0, 16'h0, 32'h0, 32'h0F, 32'hFF, 0, 0, 32'h0, 32'h0, 3, 32'h0F, 32'hFF, 1, 0};

    // Reset held for two cycles with a valid ADDU presented.
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(addu);
    tick(); expect_out("rst1", 0, 0, 0, 0, 0);
    tick(); expect_out("rst2", 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick(); expect_out("first_load", 2, 3, 4, 1, 0);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      tick();
      expect_out($sformatf("vec%0d", i), vecs[i].e_ope, vecs[i].e_a, vecs[i].e_b,
                 vecs[i].e_valid, vecs[i].e_illegal);
    end

    // Stall holds ADDU while XOR waits in ID.
    drive(addu);
    tick(); expect_out("pre_stall", 2, 3, 4, 1, 0);
    drive(xorv); stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); expect_out($sformatf("stall%0d", i), 2, 3, 4, 1, 0);
    end
    flush = 1'b1;
    tick(); expect_out("flush_stall", 0, 0, 0, 0, 0);
    flush = 1'b0; stall = 1'b0;
    tick(); expect_out("post_flush", 3, 32'h0F, 32'hFF, 1, 0);

    // Flush alone, then reset mid-stream while stalled.
    flush = 1'b1;
    tick(); expect_out("flush_only", 0, 0, 0, 0, 0);
    flush = 1'b0;
    drive(vecs[8]);
    tick(); expect_out("ill_load", 15, 0, 0, 1, 1);
    rst = 1'b1; stall = 1'b1;
    tick(); expect_out("rst_mid", 0, 0, 0, 0, 0);
    rst = 1'b0; stall = 1'b0;
    drive(addu);
    tick(); expect_out("after_rst", 2, 3, 4, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
